// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_pkg
// Description : Shared VGA frame-memory definitions used by the display-side
//               address sequencer and the write-side vram_writer.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Default video RAM geometry: 128x128 RGB332 frame in a 14-bit space
    localparam int c_ADDR_W      = 14;
    localparam int c_DATA_W      = 8;
    localparam int c_FRAME_WORDS = 16384;

    // Write-side frame sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_fifo
// Description : Small synchronous FIFO (pointer plus occupancy count) that
//               buffers accepted pixels until the RAM write port is granted.
//               dout presents the head entry combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    input  logic              flush
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);

    logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    // Guard the handshakes so a stray push/pop can never corrupt occupancy
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full  = (r_count == c_DEPTH);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Storage write; data words carry no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the buffer like reset
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_writer.sv
`default_nettype none
// ============================================================================
// Module      : vram_writer
// Description : Fills the video RAM with one frame of pixels. Pixels arrive
//               over valid/ready, are buffered in pixel_fifo and written to
//               sequential addresses only in cycles where the display side
//               grants the RAM port (wr_allow).
// Revision    : 1.0 - initial release
// ============================================================================
module vram_writer
    import vga_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int FRAME_WORDS = c_FRAME_WORDS,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    input  logic              wr_allow,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              frame_done
);

    // Counters are one bit wider than the address so a full frame is countable
    localparam int                  c_CNT_W     = ADDR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FRAME     = c_CNT_W'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0]   c_LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    wr_state_t          r_state;
    wr_state_t          w_state_nxt;
    logic               w_clear;

    logic [c_CNT_W-1:0] r_accept_cnt;
    logic [c_CNT_W-1:0] r_write_cnt;
    logic [ADDR_W-1:0]  r_addr;

    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_data;

    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_fifo_dout;

    // Accept only while a frame is open, room remains and the frame is not
    // yet fully accepted; depends on registered state only
    assign pix_ready = (r_state == ACTIVE) && !w_full && (r_accept_cnt < c_FRAME);
    assign w_push    = pix_valid && pix_ready;

    // Drain one word per granted cycle; an abort suppresses the write so the
    // RAM port is quiet in the following cycle
    assign w_pop     = (r_state == ACTIVE) && !w_empty && wr_allow && !abort;

    // A new frame or an abort both leave the buffer empty
    assign w_flush   = abort || w_clear;

    assign busy       = (r_state == ACTIVE);
    assign frame_done = (r_state == DONE);

    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;

    pixel_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_pixel_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (pix_data),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .flush (w_flush)
    );

    // Frame sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides everything, including a start
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ACTIVE;
                    w_clear     = 1'b1;
                end
            end
            ACTIVE: begin
                if (r_write_cnt == c_FRAME) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            w_state_nxt = IDLE;
            w_clear     = 1'b0;
        end
    end

    // Accept/write counters and the RAM address counter
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_accept_cnt <= '0;
            r_write_cnt  <= '0;
            r_addr       <= '0;
        end else begin
            if (w_push) begin
                r_accept_cnt <= r_accept_cnt + c_CNT_W'(1);
            end
            if (w_pop) begin
                r_write_cnt <= r_write_cnt + c_CNT_W'(1);
                // Return to 0 after the last frame address even when the
                // frame is smaller than the address space
                if (r_addr == c_LAST_ADDR) begin
                    r_addr <= '0;
                end else begin
                    r_addr <= r_addr + ADDR_W'(1);
                end
            end
        end
    end

    // Registered RAM write port; address/data hold between writes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_mem_we <= w_pop;
            if (w_pop) begin
                r_mem_addr <= r_addr;
                r_mem_data <= w_fifo_dout;
            end
        end
    end

endmodule
`default_nettype wire
